// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap CSRs, timer-interrupt / exception entry and
// mret handling at the commit boundary. Each trap or mret produces a
// one-cycle front-end redirect one cycle after the committing instruction.
module trap_ctrl #(
   parameter int unsigned          XLEN        = 64,
   parameter logic [XLEN-1:0]      RESET_MTVEC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tint,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] commit_npc,
   input  logic            exc_valid,
   input  logic [XLEN-1:0] exc_cause,
   input  logic            mret_valid,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            MIE,
   output logic            MTIE,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;

   localparam logic [XLEN-1:0] EPC_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] MCAUSE_MTI  = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
   localparam logic [XLEN-1:0] MTI_VEC_OFF = XLEN'(28);

   typedef enum logic {RUN, REDIR} state_t;

   state_t            state_q, state_d;
   logic              mie_q, mie_d;
   logic              mpie_q, mpie_d;
   logic [1:0]        mpp_q, mpp_d;
   logic              mtie_q, mtie_d;
   logic [XLEN-1:0]   mtvec_q, mtvec_d;
   logic [XLEN-1:0]   mscratch_q, mscratch_d;
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mcause_q, mcause_d;
   logic [XLEN-1:0]   rpc_q, rpc_d;

   // State and CSR registers; reset also aborts an in-flight redirect pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mpp_q      <= 2'b11;
         mtie_q     <= 1'b0;
         mtvec_q    <= RESET_MTVEC;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         rpc_q      <= '0;
      end else begin
         state_q    <= state_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mpp_q      <= mpp_d;
         mtie_q     <= mtie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         rpc_q      <= rpc_d;
      end
   end

   // Commit-boundary decisions: exception > mret > timer interrupt > CSR write
   always_comb begin
      state_d    = state_q;
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mpp_d      = mpp_q;
      mtie_d     = mtie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      rpc_d      = rpc_q;

      if (state_q == REDIR) begin
         // Pipeline is flushing: every commit-side input is ignored.
         state_d = RUN;
      end else if (commit_valid) begin
         if (exc_valid) begin
            // Faulting instruction did not complete, so its CSR write is dropped.
            mepc_d   = commit_pc & EPC_MASK;
            mcause_d = exc_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = 2'b11;
            rpc_d    = {mtvec_q[XLEN-1:2], 2'b00};
            state_d  = REDIR;
         end else begin
            // The retiring instruction's CSR write lands first; mret / trap
            // updates below then override any field they share with it.
            if (csr_we) begin
               case (csr_waddr)
                  A_MSTATUS: begin
                     if (!mret_valid) begin
                        mie_d  = csr_wdata[3];
                        mpie_d = csr_wdata[7];
                        mpp_d  = csr_wdata[12:11];
                     end
                  end
                  A_MIE:      mtie_d     = csr_wdata[7];
                  A_MTVEC:    mtvec_d    = {csr_wdata[XLEN-1:2],
                                            csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
                  A_MSCRATCH: mscratch_d = csr_wdata;
                  A_MEPC:     mepc_d     = csr_wdata & EPC_MASK;
                  A_MCAUSE:   mcause_d   = csr_wdata;
                  default:    ;
               endcase
            end

            if (mret_valid) begin
               mie_d   = mpie_q;
               mpie_d  = 1'b1;
               mpp_d   = 2'b11;
               rpc_d   = mepc_q;
               state_d = REDIR;
            end else if (tint) begin
               // Interrupt is taken after the instruction, so resume at npc.
               mepc_d   = commit_npc & EPC_MASK;
               mcause_d = MCAUSE_MTI;
               mpie_d   = mie_d;
               mie_d    = 1'b0;
               mpp_d    = 2'b11;
               rpc_d    = {mtvec_d[XLEN-1:2], 2'b00};
               if (mtvec_d[1:0] == 2'b01) begin
                  rpc_d = rpc_d + MTI_VEC_OFF;
               end
               state_d  = REDIR;
            end
         end
      end
   end

   // Combinational CSR read port; unimplemented addresses read zero
   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         A_MSTATUS: begin
            csr_rdata[3]     = mie_q;
            csr_rdata[7]     = mpie_q;
            csr_rdata[12:11] = mpp_q;
         end
         A_MIE:      csr_rdata[7] = mtie_q;
         A_MTVEC:    csr_rdata    = mtvec_q;
         A_MSCRATCH: csr_rdata    = mscratch_q;
         A_MEPC:     csr_rdata    = mepc_q;
         A_MCAUSE:   csr_rdata    = mcause_q;
         A_MIP:      csr_rdata[7] = tint;
         default:    csr_rdata    = '0;
      endcase
   end

   assign MIE            = mie_q;
   assign MTIE           = mtie_q;
   assign redirect_valid = (state_q == REDIR);
   assign redirect_pc    = rpc_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap controller sitting directly downstream of the CLINT timer block.
- Consumes its `tint` output and supplies the `MIE`/`MTIE` enables that block gates with.
- Holds the M-mode trap CSRs and takes timer interrupts and synchronous exceptions at the instruction-commit boundary.
- Executes `mret` and issues a one-cycle PC redirect plus flush to the core front end.

Parameters:
- XLEN, 64, datapath/CSR width.
- RESET_MTVEC, 64'h8000_0000, reset value of mtvec (MODE bits 00).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset (0 = reset asserted)
- tint  in  1  timer interrupt request from CLINT (already gated by MIE && MTIE)
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of retiring instruction
- commit_npc  in  XLEN  PC of next sequential/branch target of retiring instruction
- exc_valid  in  1  retiring instruction raised a synchronous exception (qualified by commit_valid)
- exc_cause  in  XLEN  exception code (MSB 0)
- mret_valid  in  1  retiring instruction is mret (qualified by commit_valid)
- csr_we  in  1  CSR write from retiring instruction (qualified by commit_valid)
- csr_waddr  in  12  CSR write address
- csr_wdata  in  XLEN  CSR write data (final value, RMW done upstream)
- csr_raddr  in  12  CSR read address
- csr_rdata  out  XLEN  combinational CSR read data
- MIE  out  1  mstatus.MIE
- MTIE  out  1  mie.MTIE (bit 7)
- redirect_valid  out  1  one-cycle pulse: front end must fetch from redirect_pc and flush younger instructions
- redirect_pc  out  XLEN  redirect target

Behaviour:
- CSRs implemented:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] stored; others read 0.
  - mie 0x304: MTIE[7] only.
  - mtvec 0x305: BASE[XLEN-1:2], MODE[1:0]; MODE values 2/3 written as 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: MTIP[7] = tint, read-only, writes ignored.
- Unimplemented addresses read 0; writes to them are ignored.
- Reset (rst=0, async) values:
  - mstatus: MIE=0, MPIE=0, MPP=2'b11.
  - mie=0, mtvec=RESET_MTVEC, mscratch=mepc=mcause=0.
  - state=RUN, redirect_valid=0, redirect_pc=0.
- FSM states: RUN, REDIR.
- RUN, evaluated only when commit_valid=1, in this priority order:
  1. exc_valid:
     - mepc<=commit_pc, mcause<=exc_cause.
     - MPIE<=MIE, MIE<=0, MPP<=11.
     - redirect_pc<={mtvec.BASE,2'b00}.
     - Go to REDIR.
  2. mret_valid:
     - MIE<=MPIE, MPIE<=1, MPP<=11.
     - redirect_pc<=mepc.
     - Go to REDIR.
  3. tint=1 (interrupt taken after the retiring instruction completes):
     - mepc<=commit_npc, mcause<={1'b1,63'd7}.
     - MPIE<=MIE, MIE<=0.
     - redirect_pc<=mtvec.BASE<<2, plus 4*7=28 if MODE=01.
     - Go to REDIR.
  4. Otherwise: csr_we performs the write; stay in RUN.
- Simultaneous events:
  - A csr_we in the same cycle as an exception is discarded; the instruction did not complete.
  - A csr_we with a tint-trap is applied first. The trap updates then override the same fields. Example: a write of mstatus.MIE=1 followed by trap entry yields MPIE=1 (the written value), MIE=0.
  - A csr_we with mret is applied to non-mstatus CSRs only. mret mstatus updates win.
- REDIR:
  - redirect_valid=1 for exactly one cycle; next state RUN.
  - commit_valid, tint, and csr_we are ignored in REDIR (pipeline is flushing).
  - Latency: event at cycle N → redirect_valid at cycle N+1.
- tint with commit_valid=0 is not taken; it stays pending until the next commit.
- tint is not re-sampled internally. The MIE=0 on entry deasserts tint upstream, which prevents nested timer traps.
- redirect_valid=0 in RUN.
- Reset asserted mid-REDIR: the pulse is aborted; state returns to RUN with reset values.
- Arithmetic is XLEN-wide; vectored address add wraps modulo 2^XLEN.

Test Plan:
- Reset, then read every CSR → mstatus=0x1800, mtvec=0x8000_0000, all others 0, redirect_valid=0.
- Timer trap:
  - Stimulus: write mtvec=0x8000_1000, mie=0x80, mstatus=0x8; then tint=1 with commit_valid=1, commit_npc=0x8000_0040.
  - Response, next cycle: redirect_valid=1, redirect_pc=0x8000_1000.
  - Response, CSRs: mepc=0x8000_0040, mcause=0x8000_0000_0000_0007, mstatus=0x1880, MIE=0.
- Vectored mode: mtvec=0x8000_1001, timer trap → redirect_pc=0x8000_101C.
- Exception beats interrupt:
  - Stimulus: exc_valid=1, exc_cause=11, commit_pc=0x8000_0100, tint=1, csr_we to mscratch=0x55.
  - Response: mepc=0x8000_0100, mcause=11, mscratch unchanged.
  - Response: tint is trapped on the first commit after REDIR.
- mret: mepc=0x8000_0200, MPIE=1 → redirect_pc=0x8000_0200, MIE=1, MPIE=1; commit_valid during REDIR is ignored.
- Async reset asserted during REDIR (mid-cycle) → redirect_valid drops immediately, all CSRs return to reset values.
